// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - Multiplexed 7-segment scan controller with frame-aligned value loading
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN (suppress leading-zero digits)
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 25000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Load_Valid,
  input  logic [4*NUM_DIGITS-1:0] i_Load_Value,
  output logic                    o_Load_Ready,
  output logic [3:0]              o_Bin_Num,
  output logic [NUM_DIGITS-1:0]   o_Digit_Sel,
  output logic                    o_Frame_Start,
  output logic                    o_Digit_Err
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  scan_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx, idx_next;

  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pending_valid;
  logic                    frame_start;
  logic                    boundary;
  logic                    accept;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   lz_mask;

  assign accept       = i_Load_Valid && !pending_valid;
  assign o_Load_Ready = !pending_valid;
  assign o_Frame_Start = frame_start;

  // The shared decoder input tracks the current slot's digit for the whole slot,
  // so the blanking gap gives the registered decoder time to settle.
  assign cur_nib   = active[{idx, 2'b00} +: 4];
  assign o_Bin_Num = cur_nib;

  // Scan state register: slot phase, cycle counter and digit index
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // Next-state sequencing and digit-enable / error outputs
  always_comb begin
    state_next  = state;
    cnt_next    = cnt + 1'b1;
    idx_next    = idx;
    boundary    = 1'b0;
    o_Digit_Sel = '0;
    o_Digit_Err = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_next = DRIVE;
          cnt_next   = '0;
        end
      end
      DRIVE: begin
        // Invalid BCD digits stay dark; suppressed leading zeros stay dark silently
        if (cur_nib > 4'd9) begin
          o_Digit_Err = (cnt == '0);
        end else if (!lz_mask[idx]) begin
          o_Digit_Sel = NUM_DIGITS'(1) << idx;
        end
        if (cnt == DRIVE_LAST) begin
          state_next = BLANK;
          cnt_next   = '0;
          if (idx == IDX_LAST) begin
            idx_next = '0;
            boundary = 1'b1;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  // Load handshake: hold one pending value and swap it in only between frames
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (accept) begin
        pending       <= i_Load_Value;
        pending_valid <= 1'b1;
      end else if (boundary && pending_valid) begin
        active        <= pending;
        pending_valid <= 1'b0;
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_pending;
  logic                  all_zero;

  // A digit is a leading zero when it and every more-significant nibble are zero;
  // digit 0 is never blanked so a zero value still reads "0".
  always_comb begin
    lz_pending = '0;
    all_zero   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero      = all_zero && (pending[4*k +: 4] == 4'd0);
      lz_pending[k] = all_zero;
    end
  end

  // Suppression mask follows the active value, captured when it is applied
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      lz_mask <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    end else if (!accept && boundary && pending_valid) begin
      lz_mask <= lz_pending;
    end
  end
`else
  assign lz_mask = '0;
`endif

endmodule
